// File: rtl/fetch_queue_ifid.sv
// Fetch queue + IF/ID register: issues PCF to imem, buffers {PC,instr} in a DEPTH-entry in-order queue.
// Latency: accept at t, rvalid at t+L, ValidD after edge t+L+1 (t+L when FETCH_BYPASS_EN is defined).
// Backpressure: StallF=1 whenever no request is accepted (queue full, FlushD, or imem not ready).
// Optional feature macro: FETCH_BYPASS_EN (head response loads IF/ID directly from imem_rdata).
module fetch_queue_ifid #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        StallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  // In-flight requests can reach 2*DEPTH: dropped ones plus a full refilled queue.
  localparam int unsigned IW = $clog2(2 * DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]    pc_q    [DEPTH];
  logic [31:0]    instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  fptr;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  drop_cnt;
  logic [IW-1:0]  inflight;

  logic        accept;
  logic        resp;
  logic        fill;
  logic        pop;
  logic        head_rdy;
  logic [31:0] head_pc;
  logic [31:0] head_instr;

  assign imem_req  = ~rst & ~FlushD & (occ != FULL);
  assign accept    = imem_req & imem_ready;
  assign StallF    = ~accept;
  assign imem_addr = PCF;

  // A response with nothing outstanding is ignored; one owed to a squashed request is dropped.
  assign resp      = imem_rvalid & (inflight != '0);
  assign fill      = resp & (drop_cnt == '0);
  assign head_rdy  = (occ != '0) & filled[head];
  assign head_pc   = pc_q[head];

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // Head is the oldest unfilled entry exactly when it is the one being filled now.
  assign bypass     = fill & (occ != '0) & ~filled[head] & (fptr == head);
  assign head_instr = bypass ? imem_rdata : instr_q[head];
  assign pop        = ~FlushD & ~StallD & (head_rdy | bypass);
`else
  assign head_instr = instr_q[head];
  assign pop        = ~FlushD & ~StallD & head_rdy;
`endif

  // Queue payload storage; contents are only meaningful under the filled/occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (accept) pc_q[tail]    <= PCF;
    if (fill)   instr_q[fptr] <= imem_rdata;
  end

  // Pointers, fill flags, occupancy, in-flight and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      occ      <= '0;
      filled   <= '0;
      drop_cnt <= '0;
      inflight <= '0;
    end else if (FlushD) begin
      // No request goes out in a flush cycle; a response arriving now is discarded on the spot,
      // so only the requests still owed afterwards are counted for dropping.
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      occ      <= '0;
      filled   <= '0;
      inflight <= inflight - IW'(resp);
      drop_cnt <= CW'(inflight - IW'(resp));
    end else begin
      if (accept) begin
        filled[tail] <= 1'b0;
        tail         <= tail + PW'(1);
      end
      if (fill) begin
        filled[fptr] <= 1'b1;
        fptr         <= fptr + PW'(1);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      occ      <= occ + CW'(accept) - CW'(pop);
      inflight <= inflight + IW'(accept) - IW'(resp);
    end
  end

  // IF/ID register: flush beats stall beats load beats bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSN;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd4;
    end else if (FlushD) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSN;
    end else if (!StallD) begin
      if (pop) begin
        ValidD   <= 1'b1;
        InstrD   <= head_instr;
        PCD      <= head_pc;
        PCPlus4D <= head_pc + 32'd4;
      end else begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_ifid.sv
module tb_fetch_queue_ifid;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = 32'd0;
  logic        StallF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_queue_ifid #(.DEPTH(4), .NOP_INSN(32'h00000013)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .StallF(StallF),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallD(StallD), .FlushD(FlushD), .ValidD(ValidD), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory / PC-generator model state
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_hold = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] pend_a[$];
  int          pend_d[$];
  int          acc_cnt = 0;
  bit          acc_now = 1'b0;
  bit          upd_edge = 1'b0;
  bit          flush_edge = 1'b0;

  // Scoreboard
  logic [31:0] exp_pc[$];
  logic [31:0] exp_in[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
    exp_pc.push_back(pc);
    exp_in.push_back(ins);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Address generator, in-order memory with latency mem_lat, and output monitor.
  initial forever begin
    @(posedge clk);
    cyc        = cyc + 1;
    upd_edge   = !rst && !StallD && !FlushD;
    flush_edge = !rst && FlushD;
    #1;
    if (rst) begin
      PCF         = 32'd0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end else begin
      if (flush_edge)   PCF = br_target;
      else if (acc_now) PCF = PCF + 32'd4;
      if (!mem_hold && pend_d.size() > 0 && pend_d[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_a[0]);
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
    @(negedge clk);
    if (rst) begin
      pend_a.delete();
      pend_d.delete();
      acc_now = 1'b0;
    end else begin
      acc_now = imem_req & imem_ready;
      if (acc_now) begin
        pend_a.push_back(imem_addr);
        pend_d.push_back(cyc + mem_lat);
        acc_cnt++;
      end
      if (flush_edge) begin
        chk("flush_validd", 32'(ValidD), 32'd0);
        chk("flush_instrd", InstrD, NOP);
      end else if (upd_edge) begin
        if (ValidD) begin
          if (exp_pc.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got pc %h instr %h, nothing expected", PCD, InstrD);
          end else begin
            mon_pc = exp_pc.pop_front();
            mon_in = exp_in.pop_front();
            chk("out_pcd", PCD, mon_pc);
            chk("out_instrd", InstrD, mon_in);
            chk("out_pcplus4d", PCPlus4D, mon_pc + 32'd4);
          end
        end else begin
          chk("bubble_instrd", InstrD, NOP);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(3);
    @(negedge clk);
    chk("rst_validd", 32'(ValidD), 32'd0);
    chk("rst_instrd", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcplus4d", PCPlus4D, 32'd4);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_stallf", 32'(StallF), 32'd1);
    tick(1);
    rst = 1'b0;

    // Stream, L=1: 0,4,8
    push_exp(32'h0000_0000, 32'hA500_0000);
    push_exp(32'h0000_0004, 32'hA500_0004);
    push_exp(32'h0000_0008, 32'hA500_0008);
    imem_ready = 1'b1;
    tick(1);
    @(negedge clk);
    chk("lat_edge1_validd", 32'(ValidD), 32'd0);
    tick(1);
    @(negedge clk);
    chk("lat_edge2_validd", 32'(ValidD), 32'(BYP));
    tick(1);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("lat_edge3_validd", 32'(ValidD), 32'd1);
    tick(6);
    chk("stream_drained", 32'(exp_pc.size()), 32'd0);

    // Full: responses held, exactly 4 accepts
    begin
      int base;
      base = acc_cnt;
      push_exp(32'h0000_000C, 32'hA500_000C);
      push_exp(32'h0000_0010, 32'hA500_0010);
      push_exp(32'h0000_0014, 32'hA500_0014);
      push_exp(32'h0000_0018, 32'hA500_0018);
      mem_hold   = 1'b1;
      imem_ready = 1'b1;
      tick(6);
      @(negedge clk);
      chk("full_accepts", 32'(acc_cnt - base), 32'd4);
      chk("full_stallf", 32'(StallF), 32'd1);
      chk("full_imem_req", 32'(imem_req), 32'd0);
      tick(1);
      imem_ready = 1'b0;
      mem_hold   = 1'b0;
      tick(10);
      chk("full_drained", 32'(exp_pc.size()), 32'd0);
    end

    // StallD for 3 cycles while responses arrive
    push_exp(32'h0000_001C, 32'hA500_001C);
    push_exp(32'h0000_0020, 32'hA500_0020);
    push_exp(32'h0000_0024, 32'hA500_0024);
    StallD     = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (i == 2) begin
        StallD     = 1'b0;
        imem_ready = 1'b0;
      end
      @(negedge clk);
      chk("stall_pcd", PCD, 32'h0000_0018);
      chk("stall_instrd", InstrD, NOP);
      chk("stall_validd", 32'(ValidD), 32'd0);
    end
    tick(8);
    chk("stall_drained", 32'(exp_pc.size()), 32'd0);

    // Flush with 3 in flight (L=4), branch target 0x100
    mem_lat   = 4;
    br_target = 32'h0000_0100;
    push_exp(32'h0000_0100, 32'hA500_0100);
    push_exp(32'h0000_0104, 32'hA500_0104);
    imem_ready = 1'b1;
    tick(3);
    FlushD = 1'b1;
    @(negedge clk);
    chk("flush_no_req", 32'(imem_req), 32'd0);
    tick(1);
    FlushD = 1'b0;
    @(negedge clk);
    chk("flush_drop_cnt", 32'(dut.drop_cnt), 32'd3);
    tick(2);
    imem_ready = 1'b0;
    tick(12);
    chk("flush_drained", 32'(exp_pc.size()), 32'd0);

    // FlushD + StallD + rvalid in one cycle (L=3), target 0x300
    mem_lat   = 3;
    br_target = 32'h0000_0300;
    push_exp(32'h0000_0300, 32'hA500_0300);
    imem_ready = 1'b1;
    tick(3);
    FlushD = 1'b1;
    StallD = 1'b1;
    @(negedge clk);
    chk("fsr_rvalid_present", 32'(imem_rvalid), 32'd1);
    tick(1);
    FlushD = 1'b0;
    StallD = 1'b0;
    @(negedge clk);
    chk("fsr_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    tick(1);
    imem_ready = 1'b0;
    tick(10);
    chk("fsr_drained", 32'(exp_pc.size()), 32'd0);

    // Asynchronous reset mid-run
    mem_lat    = 1;
    imem_ready = 1'b1;
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_validd", 32'(ValidD), 32'd0);
    chk("arst_instrd", InstrD, NOP);
    chk("arst_pcd", PCD, 32'd0);
    chk("arst_pcplus4d", PCPlus4D, 32'd4);
    chk("arst_stallf", 32'(StallF), 32'd1);
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    tick(2);
    @(negedge clk);
    chk("arst_hold_stallf", 32'(StallF), 32'd1);
    tick(1);
    push_exp(32'h0000_0000, 32'hA500_0000);
    rst = 1'b0;
    tick(1);
    imem_ready = 1'b0;
    tick(6);
    chk("arst_drained", 32'(exp_pc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
